// File: rtl/div_arbiter.sv
// div_arbiter
// -----------
// Two-requester round-robin front end for the shared radix-4 divider. A
// granted request has its operands latched onto div_src1/div_src2. The block
// then pulses div_enable for four cycles and captures quotient, remainder and
// overflow into a response that is held until the consumer takes it.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   reqN_valid/ready/a/b     requester N handshake, dividend a, divisor b
//   rsp_valid/ready          response handshake (held while valid)
//   rsp_id/quot/rem/ov       owning requester, quotient, remainder, div-by-0
//   div_rst                  active-high divider reset (combinational !rst)
//   div_enable               divider step enable (registered)
//   div_src1/div_src2        divider dividend/divisor (registered, held)
//   div_des1/des2/desOv      divider remainder/quotient/overflow
//
// Configuration
//   DIV_ARB_ZERO_BYPASS_EN   when defined, b==0 requests skip the divider and
//                            answer with quot=FF, rem=a, ov=1 one cycle later.

module div_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_quot,
    output logic [7:0] rsp_rem,
    output logic       rsp_ov,
    output logic       div_rst,
    output logic       div_enable,
    output logic [7:0] div_src1,
    output logic [7:0] div_src2,
    input  logic [7:0] div_des1,
    input  logic [7:0] div_des2,
    input  logic       div_desOv
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       last_q, last_d;
    logic [7:0] src1_q, src1_d;
    logic [7:0] src2_q, src2_d;
    logic       id_q, id_d;
    logic [7:0] quot_q, quot_d;
    logic [7:0] rem_q, rem_d;
    logic       ov_q, ov_d;
    logic       valid_q, valid_d;
    logic       en_q, en_d;

    logic       gnt;
    logic       accept;
    logic [7:0] sel_a;
    logic [7:0] sel_b;

    // Arbitration: a lone requester wins outright; on a tie the requester
    // that was not granted last time wins. Ready is masked while reset is
    // asserted so nothing appears accepted during reset.
    always_comb begin
        if (req0_valid && req1_valid) begin
            gnt = ~last_q;
        end else begin
            gnt = req1_valid;
        end
        accept = rst && (state_q == IDLE) && (req0_valid || req1_valid);
        sel_a  = gnt ? req1_a : req0_a;
        sel_b  = gnt ? req1_b : req0_b;
    end

    assign req0_ready = accept && !gnt;
    assign req1_ready = accept && gnt;

    // The divider's internal cycle counter shares our reset so that a reset
    // in the middle of a burst cannot leave it out of step with cnt_q.
    assign div_rst = ~rst;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        id_d    = id_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        ov_d    = ov_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    src1_d = sel_a;
                    src2_d = sel_b;
                    id_d   = gnt;
                    last_d = gnt;
                    cnt_d  = 2'd0;
`ifdef DIV_ARB_ZERO_BYPASS_EN
                    if (sel_b == 8'd0) begin
                        state_d = DONE;
                        quot_d  = 8'hFF;
                        rem_d   = sel_a;
                        ov_d    = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
`else
                    state_d = RUN;
`endif
                end
            end
            RUN: begin
                // cnt_q wraps from 3 back to 0, leaving it ready for the next burst.
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    quot_d  = div_des2;
                    rem_d   = div_des1;
                    ov_d    = div_desOv;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered from the next state so enable/valid line up exactly
        // with the RUN and DONE cycles.
        en_d    = (state_d == RUN);
        valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            last_q  <= 1'b1;
            src1_q  <= 8'd0;
            src2_q  <= 8'd0;
            id_q    <= 1'b0;
            quot_q  <= 8'd0;
            rem_q   <= 8'd0;
            ov_q    <= 1'b0;
            valid_q <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            id_q    <= id_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            ov_q    <= ov_d;
            valid_q <= valid_d;
            en_q    <= en_d;
        end
    end

    assign rsp_valid  = valid_q;
    assign rsp_id     = id_q;
    assign rsp_quot   = quot_q;
    assign rsp_rem    = rem_q;
    assign rsp_ov     = ov_q;
    assign div_enable = en_q;
    assign div_src1   = src1_q;
    assign div_src2   = src2_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Testbench for div_arbiter. Contains a behavioural stand-in for the
// external radix-4 divider: results are valid only on the fourth enabled
// cycle of its own counter, so any misalignment shows up as garbage.

module tb_div_arbiter;

`ifdef DIV_ARB_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready;
    logic [7:0] req0_a, req0_b;
    logic       req1_valid, req1_ready;
    logic [7:0] req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_ov;
    logic [7:0] rsp_quot, rsp_rem;
    logic       div_rst, div_enable;
    logic [7:0] div_src1, div_src2;
    logic [7:0] div_des1, div_des2;
    logic       div_desOv;

    always #5 clk = ~clk;

    div_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_quot   (rsp_quot),
        .rsp_rem    (rsp_rem),
        .rsp_ov     (rsp_ov),
        .div_rst    (div_rst),
        .div_enable (div_enable),
        .div_src1   (div_src1),
        .div_src2   (div_src2),
        .div_des1   (div_des1),
        .div_des2   (div_des2),
        .div_desOv  (div_desOv)
    );

    // Divider stand-in.
    logic [1:0] dv_cyc;
    always @(posedge clk or posedge div_rst) begin
        if (div_rst) dv_cyc <= 2'd0;
        else if (div_enable) dv_cyc <= dv_cyc + 2'd1;
    end
    logic dv_final;
    assign dv_final  = div_enable && (dv_cyc == 2'd3);
    assign div_des2  = !dv_final ? 8'h5A : (div_src2 == 8'd0) ? 8'hFF : div_src1 / div_src2;
    assign div_des1  = !dv_final ? 8'hC3 : (div_src2 == 8'd0) ? div_src1 : div_src1 % div_src2;
    assign div_desOv = dv_final ? (div_src2 == 8'd0) : 1'b1;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
    } op_t;

    op_t q0[$];
    op_t q1[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state: one outstanding transaction at a time.
    bit  m_busy    = 1'b0;
    bit  m_last    = 1'b1;
    bit  m_id      = 1'b0;
    op_t m_cur;
    int  m_acc_cyc = 0;
    int  m_en      = 0;
    int  m_wait    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Drives both requesters from their queues, checks every cycle against
    // the model, and returns once both queues are drained and answered.
    // hold: response cycles the consumer stalls before it may take it.
    // pct:  probability (%) that the consumer takes it after the stall.
    task automatic run_stream(input int hold, input int pct);
        int       budget;
        bit       g0, g1, exp_rv;
        int       lat, exp_en;
        logic [7:0] eq, er;
        op_t      op;
        budget = 3000;
        while ((q0.size() > 0 || q1.size() > 0 || m_busy) && budget > 0) begin
            @(negedge clk);
            budget--;
            cyc++;
            req0_valid = (q0.size() > 0);
            if (req0_valid) begin req0_a = q0[0].a; req0_b = q0[0].b; end
            req1_valid = (q1.size() > 0);
            if (req1_valid) begin req1_a = q1[0].a; req1_b = q1[0].b; end

            lat    = (BYPASS && m_cur.b == 8'd0) ? 1 : 5;
            exp_en = (BYPASS && m_cur.b == 8'd0) ? 0 : 4;
            exp_rv = m_busy && (cyc - m_acc_cyc >= lat);
            if (exp_rv) begin
                rsp_ready = (m_wait >= hold) && ($urandom_range(0, 99) < pct);
                m_wait++;
            end else begin
                rsp_ready = 1'($urandom_range(0, 1));
            end
            #1;

            g0 = 1'b0;
            g1 = 1'b0;
            if (!m_busy) begin
                if (req0_valid && req1_valid) begin
                    g0 = m_last;
                    g1 = !m_last;
                end else begin
                    g0 = req0_valid;
                    g1 = req1_valid;
                end
            end
            chk("req0_ready", req0_ready, g0);
            chk("req1_ready", req1_ready, g1);
            chk("rsp_valid", rsp_valid, exp_rv);

            if (m_busy && div_enable) begin
                m_en++;
                chk("div_src1_hold", div_src1, m_cur.a);
                chk("div_src2_hold", div_src2, m_cur.b);
            end
            if (!m_busy) chk("enable_idle", div_enable, 0);

            if (exp_rv) begin
                eq = (m_cur.b == 8'd0) ? 8'hFF : m_cur.a / m_cur.b;
                er = (m_cur.b == 8'd0) ? m_cur.a : m_cur.a % m_cur.b;
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_quot", rsp_quot, eq);
                chk("rsp_rem", rsp_rem, er);
                chk("rsp_ov", rsp_ov, (m_cur.b == 8'd0));
                if (rsp_ready) begin
                    chk("enable_cycles", m_en, exp_en);
                    $display("rsp id=%0d %0d/%0d -> q=%0d r=%0d ov=%0d", m_id, m_cur.a, m_cur.b,
                             rsp_quot, rsp_rem, rsp_ov);
                    m_busy = 1'b0;
                end
            end

            if (g0 || g1) begin
                op        = g1 ? q1.pop_front() : q0.pop_front();
                m_cur     = op;
                m_id      = g1;
                m_last    = g1;
                m_busy    = 1'b1;
                m_acc_cyc = cyc;
                m_en      = 0;
                m_wait    = 0;
            end
        end
        chk("stream_in_budget", (budget > 0), 1);
        @(negedge clk);
        cyc++;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
    endtask

    initial begin
        op_t o;
        rst        = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_a     = 8'd1;
        req0_b     = 8'd1;
        req1_a     = 8'd2;
        req1_b     = 8'd1;
        rsp_ready  = 1'b0;

        // Reset state, with both requesters pushing.
        @(negedge clk);
        #1;
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_quot", rsp_quot, 0);
        chk("rst_rsp_rem", rsp_rem, 0);
        chk("rst_rsp_ov", rsp_ov, 0);
        chk("rst_div_enable", div_enable, 0);
        chk("rst_div_src1", div_src1, 0);
        chk("rst_div_src2", div_src2, 0);
        chk("rst_div_rst", div_rst, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst        = 1'b1;
        #1;
        chk("run_div_rst", div_rst, 0);

        // Tie right after reset: requester 0 first, then 1.
        o.a = 8'd100; o.b = 8'd9;  q0.push_back(o);
        o.a = 8'd255; o.b = 8'd16; q1.push_back(o);
        run_stream(0, 100);

        // Single request.
        o.a = 8'd200; o.b = 8'd7; q0.push_back(o);
        run_stream(0, 100);

        // Backpressure: response stalled 10 cycles while requester 1 waits.
        o.a = 8'd50; o.b = 8'd5; q0.push_back(o);
        o.a = 8'd99; o.b = 8'd4; q1.push_back(o);
        run_stream(10, 100);

        // Divide by zero.
        o.a = 8'd77; o.b = 8'd0; q0.push_back(o);
        run_stream(0, 100);

        // Reset asserted in the third RUN cycle.
        @(negedge clk);
        cyc++;
        req0_valid = 1'b1;
        req0_a     = 8'd123;
        req0_b     = 8'd10;
        #1;
        chk("rr_accept", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rr_enable_before", div_enable, 1);
        rst = 1'b0;
        #1;
        chk("rr_enable_dropped", div_enable, 0);
        chk("rr_rsp_dropped", rsp_valid, 0);
        chk("rr_div_rst", div_rst, 1);
        @(negedge clk);
        rst    = 1'b1;
        m_last = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("rr_no_stale_rsp", rsp_valid, 0);
            chk("rr_no_enable", div_enable, 0);
        end
        o.a = 8'd9; o.b = 8'd3; q0.push_back(o);
        run_stream(0, 100);

        // Random stream, both requesters contending, random consumer stalls.
        for (int i = 0; i < 10; i++) begin
            o.a = 8'($urandom_range(0, 255));
            o.b = (i == 3) ? 8'd0 : 8'($urandom_range(0, 255));
            q0.push_back(o);
            o.a = 8'($urandom_range(0, 255));
            o.b = 8'($urandom_range(1, 15));
            q1.push_back(o);
        end
        run_stream(0, 70);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
